banco_registradores: RTL and testbench

Parametrised register bank: DEPTH entries of WIDTH bits, one synchronous write port and two combinational read ports. It is the datapath storage element that follows the single enabled register. It adds addressing, a hardwired-zero entry, a synchronous clear-all, and optional write-to-read bypass. It sits between the control unit (which drives addresses and we) and the ALU (which consumes rdata_a and rdata_b).

---
 rtl/banco_registradores_pkg.sv | 11 +
 rtl/banco_registradores_registrador_n.sv | 35 +++
 rtl/banco_registradores.sv | 65 ++++++
 tb/tb_banco_registradores.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_pkg.sv
// Shared defaults and address-width derivation for the register bank.
package banco_pkg;

   localparam int unsigned BANCO_WIDTH = 8;
   localparam int unsigned BANCO_DEPTH = 8;

   function automatic int unsigned calc_aw(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/banco_registradores_registrador_n.sv
// Enabled WIDTH-bit register: async active-low reset, synchronous clear over enable.
module registrador_n #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   always_comb begin
      out_d = out_q;
      if (clear) begin
         out_d = '0;
      end else if (enable) begin
         out_d = in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/banco_registradores.sv
// Register bank: one synchronous write port, two combinational read ports,
// optional hardwired-zero entry 0 and optional write-to-read bypass.
module banco_registradores
   import banco_pkg::*;
#(
   parameter int unsigned WIDTH    = BANCO_WIDTH,
   parameter int unsigned DEPTH    = BANCO_DEPTH,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [DEPTH-1:0][WIDTH-1:0] entry_q;
   logic                        bypass_ok;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (ZERO_REG && (i == 0)) begin : g_zero
         assign entry_q[i] = '0;
      end else begin : g_reg
         registrador_n #(
            .WIDTH(WIDTH)
         ) u_reg (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .enable(we && (waddr == AW'(i))),
            .in    (wdata),
            .out   (entry_q[i])
         );
      end
   end

   // Zero-register suppression needs no term here: raddr==waddr==0 already reads 0.
   assign bypass_ok = BYPASS && we && !clear;

   always_comb begin
      rdata_a = entry_q[raddr_a];
      if (!reset || (ZERO_REG && (raddr_a == '0))) begin
         rdata_a = '0;
      end else if (bypass_ok && (raddr_a == waddr)) begin
         rdata_a = wdata;
      end
   end

   always_comb begin
      rdata_b = entry_q[raddr_b];
      if (!reset || (ZERO_REG && (raddr_b == '0))) begin
         rdata_b = '0;
      end else if (bypass_ok && (raddr_b == waddr)) begin
         rdata_b = wdata;
      end
   end

endmodule

// File: tb/tb_banco_registradores.sv
// Directed self-checking bench: default bank, a non-bypass twin and a 16x16 variant.
module tb_banco_registradores;

   logic        clk = 1'b0;
   logic        reset, clear, we;
   logic [2:0]  waddr, raddr_a, raddr_b;
   logic [7:0]  wdata;
   logic [7:0]  rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;

   logic        w_we;
   logic [3:0]  w_waddr, w_raddr_a, w_raddr_b;
   logic [15:0] w_wdata, w_rdata_a, w_rdata_b;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   banco_registradores u_dut (
      .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b)
   );

   banco_registradores #(.BYPASS(1'b0)) u_nb (
      .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .rdata_a(nb_rdata_a), .raddr_b(raddr_b), .rdata_b(nb_rdata_b)
   );

   banco_registradores #(.WIDTH(16), .DEPTH(16)) u_wide (
      .clk(clk), .reset(reset), .clear(clear), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
      .raddr_a(w_raddr_a), .rdata_a(w_rdata_a), .raddr_b(w_raddr_b), .rdata_b(w_rdata_b)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; we = 1'b0;
      waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      w_we = 1'b0; w_waddr = '0; w_wdata = '0; w_raddr_a = '0; w_raddr_b = '0;

      #12;
      reset   = 1'b1;
      raddr_a = 3'd3;
      raddr_b = 3'd7;
      #1;
      chk("reset_a", {8'h0, rdata_a}, 16'h0000);
      chk("reset_b", {8'h0, rdata_b}, 16'h0000);

      // Load 0xA5 into entries 1..7
      for (int unsigned i = 1; i < 8; i++) begin
         we = 1'b1; waddr = 3'(i); wdata = 8'hA5;
         tick();
      end
      we = 1'b0; raddr_a = 3'd7; raddr_b = 3'd1;
      #1;
      chk("load_a7", {8'h0, rdata_a}, 16'h00A5);
      chk("load_b1", {8'h0, rdata_b}, 16'h00A5);

      // Mid-cycle async reset pulse of 3 ns
      #1; reset = 1'b0;
      #1;
      chk("async_rst_a", {8'h0, rdata_a}, 16'h0000);
      chk("async_rst_b", {8'h0, rdata_b}, 16'h0000);
      #2; reset = 1'b1;
      #1;
      chk("post_rst_a7", {8'h0, rdata_a}, 16'h0000);
      chk("post_rst_b1", {8'h0, rdata_b}, 16'h0000);

      // Write 0x3C to entry 3 with bypass visible before the edge
      we = 1'b1; waddr = 3'd3; wdata = 8'h3C; raddr_a = 3'd3; raddr_b = 3'd3;
      #1;
      chk("bypass_pre_3", {8'h0, rdata_a}, 16'h003C);
      chk("nobyp_pre_3", {8'h0, nb_rdata_a}, 16'h0000);
      tick();
      we = 1'b0;
      #1;
      chk("wr3_a", {8'h0, rdata_a}, 16'h003C);
      chk("wr3_b", {8'h0, rdata_b}, 16'h003C);
      chk("wr3_nb", {8'h0, nb_rdata_a}, 16'h003C);
      raddr_b = 3'd4;
      #1;
      chk("other_4", {8'h0, rdata_b}, 16'h0000);

      // Hold: we=0 with junk data for 4 cycles
      wdata = 8'hFF;
      for (int unsigned i = 0; i < 4; i++) tick();
      chk("hold_3", {8'h0, rdata_a}, 16'h003C);

      // Back-to-back writes to entry 6: each value lives exactly one cycle
      raddr_b = 3'd6;
      we = 1'b1; waddr = 3'd6; wdata = 8'h01;
      tick();
      chk("b2b_first", {8'h0, nb_rdata_b}, 16'h0001);
      wdata = 8'h02;
      tick();
      we = 1'b0;
      #1;
      chk("b2b_last", {8'h0, nb_rdata_b}, 16'h0002);

      // Zero register ignores writes and never bypasses
      we = 1'b1; waddr = 3'd0; wdata = 8'h77; raddr_a = 3'd0;
      #1;
      chk("zero_pre", {8'h0, rdata_a}, 16'h0000);
      tick();
      we = 1'b0;
      #1;
      chk("zero_post", {8'h0, rdata_a}, 16'h0000);
      chk("zero_post_nb", {8'h0, nb_rdata_a}, 16'h0000);

      // Bypass vs. no-bypass on entry 5
      we = 1'b1; waddr = 3'd5; wdata = 8'h11;
      tick();
      wdata = 8'h22; raddr_b = 3'd5;
      #1;
      chk("byp_b5", {8'h0, rdata_b}, 16'h0022);
      chk("nobyp_b5", {8'h0, nb_rdata_b}, 16'h0011);
      tick();
      we = 1'b0;
      #1;
      chk("nobyp_b5_post", {8'h0, nb_rdata_b}, 16'h0022);

      // Wide variant writes
      w_we = 1'b1; w_waddr = 4'd15; w_wdata = 16'hBEEF;
      tick();
      w_waddr = 4'd9; w_wdata = 16'h1234;
      tick();
      w_we = 1'b0; w_raddr_a = 4'd15; w_raddr_b = 4'd9;
      #1;
      chk("wide_15", w_rdata_a, 16'hBEEF);
      chk("wide_9", w_rdata_b, 16'h1234);

      // Clear beats write; bypass inhibited so reads show pre-edge contents
      clear = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'h99; raddr_a = 3'd5; raddr_b = 3'd3;
      w_we = 1'b1; w_waddr = 4'd15; w_wdata = 16'hFFFF;
      #1;
      chk("clr_pre_a5", {8'h0, rdata_a}, 16'h0022);
      chk("clr_pre_b3", {8'h0, rdata_b}, 16'h003C);
      chk("clr_pre_wide", w_rdata_a, 16'hBEEF);
      tick();
      clear = 1'b0; we = 1'b0; w_we = 1'b0;
      for (int unsigned i = 1; i < 8; i++) begin
         raddr_a = 3'(i);
         #1;
         chk($sformatf("clr_entry%0d", i), {8'h0, rdata_a}, 16'h0000);
      end
      #1;
      chk("clr_wide_15", w_rdata_a, 16'h0000);
      chk("clr_wide_9", w_rdata_b, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
